// File: rtl/cache_stats_collector.sv
// Purpose: L2 cache event statistics with saturating counters, snapshot readout and hit-ratio divider.
// Latency: counters and snapshots update on the next edge; ratio_valid_o follows an accepted start by RATIO_FRAC+3 cycles (2 when hit+miss==0).
// Backpressure: none; events are counted every cycle, and ratio_start_i is dropped while the divider is not idle.
//
// Ports:
//   clk_i, reset_i      single rising-edge clock, synchronous active-high reset
//   event_valid_i       per-channel event strobes (ch0=hit, ch1=miss, ...)
//   clear_i             zero live counters and saturated flags
//   snapshot_i          copy live counters into snapshot registers
//   rd_index_i          selects the snapshot register shown on rd_count_o
//   rd_count_o          snapshot[rd_index_i], 0 for an out-of-range index
//   saturated_o         sticky per-channel "counter reached all-ones"
//   ratio_start_i       start hit/(hit+miss) from snapshot ch0/ch1
//   ratio_busy_o        divider in LOAD or DIV
//   ratio_valid_o       one-cycle pulse; ratio_q_o/ratio_div0_o are fresh
//   ratio_q_o           floor(hit/(hit+miss) * 2^RATIO_FRAC), Q1.RATIO_FRAC
//   ratio_div0_o        last result had hit+miss==0
module cache_stats_collector #(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int RATIO_FRAC = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_EVENTS-1:0]         event_valid_i,
  input  logic                          clear_i,
  input  logic                          snapshot_i,
  input  logic [$clog2(NUM_EVENTS)-1:0] rd_index_i,
  output logic [CNT_WIDTH-1:0]          rd_count_o,
  output logic [NUM_EVENTS-1:0]         saturated_o,
  input  logic                          ratio_start_i,
  output logic                          ratio_busy_o,
  output logic                          ratio_valid_o,
  output logic [RATIO_FRAC:0]           ratio_q_o,
  output logic                          ratio_div0_o
);

  localparam int IDX_W = $clog2(NUM_EVENTS);
  localparam int BIT_W = $clog2(RATIO_FRAC + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_NEAR = CNT_MAX - CNT_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // Event counters and snapshots
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0]  live_q [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  live_d [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  snap_q [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  snap_d [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] sat_q, sat_d;

  always_comb begin
    sat_d = sat_q;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      live_d[i] = live_q[i];
      // Snapshot always sees the registered count, so a same-cycle event or
      // clear lands in the live counter only.
      snap_d[i] = snapshot_i ? live_q[i] : snap_q[i];
      if (clear_i) begin
        live_d[i] = '0;
        sat_d[i]  = 1'b0;
      end else if (event_valid_i[i]) begin
        if (live_q[i] != CNT_MAX) begin
          live_d[i] = live_q[i] + CNT_WIDTH'(1);
        end
        // Flag sets on the event that makes the count all-ones and stays set.
        if (live_q[i] >= CNT_NEAR) begin
          sat_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        live_q[i] <= '0;
        snap_q[i] <= '0;
      end
      sat_q <= '0;
    end else begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        live_q[i] <= live_d[i];
        snap_q[i] <= snap_d[i];
      end
      sat_q <= sat_d;
    end
  end

  assign saturated_o = sat_q;

  // Indices with no matching channel fall through to zero.
  always_comb begin
    rd_count_o = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (rd_index_i == IDX_W'(i)) begin
        rd_count_o = snap_q[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Hit-ratio restoring divider
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DIV,
    S_DONE
  } ratio_state_e;

  ratio_state_e         state_q, state_d;
  logic [CNT_WIDTH-1:0] num_q, num_d;
  logic [CNT_WIDTH:0]   den_q, den_d;
  logic [CNT_WIDTH+1:0] rem_q, rem_d;
  logic [CNT_WIDTH+1:0] rem_sub;
  logic                 rem_ge;
  logic [RATIO_FRAC:0]  quo_q, quo_d;
  logic [RATIO_FRAC:0]  res_q, res_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 div0_q, div0_d;

  always_comb begin
    state_d       = state_q;
    num_d         = num_q;
    den_d         = den_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    bit_d         = bit_q;
    res_d         = res_q;
    div0_d        = div0_q;
    ratio_busy_o  = 1'b0;
    ratio_valid_o = 1'b0;

    rem_ge  = (rem_q >= {1'b0, den_q});
    rem_sub = rem_ge ? (rem_q - {1'b0, den_q}) : rem_q;

    case (state_q)
      S_IDLE: begin
        if (ratio_start_i) begin
          num_d   = snap_q[0];
          den_d   = {1'b0, snap_q[0]} + {1'b0, snap_q[1]};
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        ratio_busy_o = 1'b1;
        if (den_q == '0) begin
          res_d   = '0;
          div0_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          rem_d   = {2'b00, num_q};
          quo_d   = '0;
          bit_d   = BIT_W'(RATIO_FRAC);
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        ratio_busy_o = 1'b1;
        // Remainder stays below 2*D, so the shifted-out MSB is always zero.
        rem_d = rem_sub << 1;
        // Quotient bits arrive MSB first; after RATIO_FRAC+1 shifts the
        // first bit sits at position RATIO_FRAC.
        quo_d = {quo_q[RATIO_FRAC-1:0], rem_ge};
        if (bit_q == '0) begin
          // Publish on entry to DONE so the data is stable during the pulse.
          res_d   = quo_d;
          div0_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          bit_d = bit_q - BIT_W'(1);
        end
      end
      S_DONE: begin
        ratio_valid_o = 1'b1;
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      den_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      bit_q   <= '0;
      res_q   <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      den_q   <= den_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      bit_q   <= bit_d;
      res_q   <= res_d;
      div0_q  <= div0_d;
    end
  end

  assign ratio_q_o    = res_q;
  assign ratio_div0_o = div0_q;

endmodule

// File: tb/tb_cache_stats_collector.sv
// Purpose: directed bench for cache_stats_collector (default and 4-bit counter instances).
// Latency: measured from the start-sampling edge to the ratio_valid pulse.
// Backpressure: not applicable; the bench drives strobes and starts directly.
module tb_cache_stats_collector;

  localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;

  typedef struct {
    logic [8:0] q;
    logic       div0;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [3:0]  ev = '0;
  logic        clr = 1'b0, snp = 1'b0, start = 1'b0;
  logic [1:0]  idx = '0;
  logic [31:0] rd_count;
  logic [3:0]  sat;
  logic        busy, valid, div0;
  logic [8:0]  q;

  logic [3:0]  ev4 = '0;
  logic        clr4 = 1'b0, snp4 = 1'b0, start4 = 1'b0;
  logic [1:0]  idx4 = '0;
  logic [3:0]  rd4;
  logic [3:0]  sat4;
  logic        busy4, valid4, div04;
  logic [8:0]  q4;

  cache_stats_collector dut (
    .clk_i(clk), .reset_i(reset), .event_valid_i(ev), .clear_i(clr),
    .snapshot_i(snp), .rd_index_i(idx), .rd_count_o(rd_count),
    .saturated_o(sat), .ratio_start_i(start), .ratio_busy_o(busy),
    .ratio_valid_o(valid), .ratio_q_o(q), .ratio_div0_o(div0)
  );

  cache_stats_collector #(.NUM_EVENTS(4), .CNT_WIDTH(4), .RATIO_FRAC(8)) dut4 (
    .clk_i(clk), .reset_i(reset), .event_valid_i(ev4), .clear_i(clr4),
    .snapshot_i(snp4), .rd_index_i(idx4), .rd_count_o(rd4),
    .saturated_o(sat4), .ratio_start_i(start4), .ratio_busy_o(busy4),
    .ratio_valid_o(valid4), .ratio_q_o(q4), .ratio_div0_o(div04)
  );

  int     tests = 0;
  int     fails = 0;
  int     vcount = 0;
  longint m_live [4];
  longint m_snap [4];
  res_t   sb [$];

  always @(negedge clk) if (valid === 1'b1) vcount++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_live[i] = 0;
      m_snap[i] = 0;
    end
  endtask

  // One cycle of main-instance stimulus with the reference update at the edge.
  task automatic cyc(input logic [3:0] e, input logic c, input logic s);
    ev = e; clr = c; snp = s;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (s) m_snap[i] = m_live[i];
      if (c) m_live[i] = 0;
      else if (e[i] && m_live[i] < MAXV) m_live[i] = m_live[i] + 1;
    end
    #1;
    ev = '0; clr = 1'b0; snp = 1'b0;
  endtask

  task automatic cyc4(input logic [3:0] e, input logic c, input logic s);
    ev4 = e; clr4 = c; snp4 = s;
    @(posedge clk); #1;
    ev4 = '0; clr4 = 1'b0; snp4 = 1'b0;
  endtask

  task automatic check_rd(input string tag, input int i, input longint exp);
    idx = 2'(i);
    #1;
    check(tag, 64'(rd_count), exp);
  endtask

  // Drive one accepted start and queue its expected result.
  task automatic start_ratio();
    res_t   r;
    longint d;
    d = m_snap[0] + m_snap[1];
    if (d == 0) begin
      r.q = '0; r.div0 = 1'b1;
    end else begin
      r.q = 9'((m_snap[0] * 256) / d); r.div0 = 1'b0;
    end
    sb.push_back(r);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_ratio(input string tag, input int n0, input int exp_lat);
    int   n;
    res_t r;
    n = n0;
    while (valid !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      r = sb.pop_front();
      check({tag, "_q"}, 64'(q), 64'(r.q));
      check({tag, "_div0"}, 64'(div0), 64'(r.div0));
    end
  endtask

  initial begin
    int   vc0;
    int   exp_idx [4];
    model_reset();

    // 1: reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_q", 64'(q), 64'd0);
    check("rst_div0", 64'(div0), 64'd0);
    check("rst_sat", 64'(sat), 64'd0);
    for (int i = 0; i < 4; i++) check_rd("rst_rd", i, 0);
    reset = 1'b0;

    // 2: mixed counting, snapshot, ratio 100/125
    repeat (100) cyc(4'b0101, 1'b0, 1'b0);
    repeat (25)  cyc(4'b1010, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b1);
    exp_idx[0] = 100; exp_idx[1] = 25; exp_idx[2] = 100; exp_idx[3] = 25;
    for (int i = 0; i < 4; i++) check_rd("cnt_rd", i, longint'(exp_idx[i]));
    check("cnt_sat", 64'(sat), 64'd0);
    start_ratio();
    check("ratio_busy", 64'(busy), 64'd1);
    wait_ratio("ratio_100_125", 1, 11);
    check("ratio_204", 64'(q), 64'd204);

    // 3: 4-bit instance saturation
    repeat (20) cyc4(4'b0001, 1'b0, 1'b0);
    check("sat4_set", 64'(sat4), 64'b0001);
    cyc4(4'b0000, 1'b0, 1'b1);
    #1;
    check("sat4_rd", 64'(rd4), 64'd15);
    cyc4(4'b0000, 1'b1, 1'b0);
    check("sat4_clr", 64'(sat4), 64'd0);
    cyc4(4'b0000, 1'b0, 1'b1);
    #1;
    check("sat4_rd_clr", 64'(rd4), 64'd0);

    // 4: same-cycle priorities
    cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b0001, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, 1'b1);
    check_rd("clr_ev", 0, 0);
    repeat (5) cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b1);
    check_rd("snap_ev_snap", 0, 5);
    cyc(4'b0000, 1'b0, 1'b1);
    check_rd("snap_ev_live", 0, 6);
    cyc(4'b0000, 1'b1, 1'b1);
    check_rd("snap_clr_snap", 0, m_snap[0]);
    check_rd("snap_clr_old", 0, 6);
    cyc(4'b0000, 1'b0, 1'b1);
    check_rd("snap_clr_live", 0, 0);
    check("clr_keeps_q", 64'(q), 64'd204);

    // 5: ratio corner cases
    start_ratio();
    wait_ratio("ratio_div0", 1, 2);
    repeat (7) cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b1);
    start_ratio();
    wait_ratio("ratio_7_0", 1, 11);
    check("ratio_256", 64'(q), 64'd256);
    cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b0011, 1'b0, 1'b0);
    cyc(4'b0010, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b1);
    vc0 = vcount;
    start_ratio();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_ratio("ratio_1_2", 2, 11);
    check("ratio_85", 64'(q), 64'd85);
    repeat (15) @(posedge clk);
    #1;
    check("one_pulse", 64'(vcount - vc0), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);

    // 6: reset during DIV
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy", 64'(busy), 64'd1);
    vc0 = vcount;
    reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check("rdiv_busy", 64'(busy), 64'd0);
    check("rdiv_q", 64'(q), 64'd0);
    check("rdiv_div0", 64'(div0), 64'd0);
    reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("rdiv_no_pulse", 64'(vcount - vc0), 64'd0);
    cyc(4'b0011, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b1);
    start_ratio();
    wait_ratio("ratio_3_1", 1, 11);
    check("ratio_192", 64'(q), 64'd192);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
